// File: rtl/multi_controller_if.sv
// Clock/reset bundle shared by the multi-cycle MIPS control unit and its driver.
interface ctrl_bus_if;
  logic clk;
  logic reset;

  modport central (input clk, input reset);
  modport master  (output clk, output reset);
endinterface

// File: rtl/multi_controller.sv
// Multi-cycle MIPS subset control FSM (lw, sw, R-type, beq, addi, j; bne optional).
// Optional feature macro: CTRL_BNE_EN enables the bne opcode (000101).
module multi_controller (
  ctrl_bus_if.central ctrl_bus,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        i_or_d,
  output logic        ireg_enab,
  output logic [1:0]  pc_src,
  output logic        pc_enab,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_srcA,
  output logic [1:0]  alu_srcB,
  output logic [2:0]  alu_ctrl_sig,
  output logic        mem_write,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    BNE      = 4'd12
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e state_q, state_d;
  logic   pc_write, branch_eq, branch_ne;
  logic   ireg_raw, reg_write_raw, mem_write_raw;

  always_ff @(posedge ctrl_bus.clk) begin
    if (ctrl_bus.reset) state_q <= FETCH;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d       = FETCH;
    i_or_d        = 1'b0;
    ireg_raw      = 1'b0;
    pc_src        = 2'b00;
    pc_write      = 1'b0;
    branch_eq     = 1'b0;
    branch_ne     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write_raw = 1'b0;
    alu_srcA      = 1'b0;
    alu_srcB      = 2'b00;
    alu_ctrl_sig  = 3'b010;
    mem_write_raw = 1'b0;
    illegal       = 1'b0;
    unique case (state_q)
      FETCH: begin
        ireg_raw = 1'b1;
        alu_srcB = 2'b01;
        pc_write = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        alu_srcB = 2'b11;
        // Unsupported opcodes flag illegal for this one cycle and refetch.
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
`ifdef CTRL_BNE_EN
          OP_BNE:       state_d = BNE;
`endif
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
        state_d  = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        i_or_d  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      MEMWR: begin
        i_or_d        = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTE: begin
        alu_srcA = 1'b1;
        state_d  = ALUWB;
        case (funct)
          6'b100010: alu_ctrl_sig = 3'b110;
          6'b100100: alu_ctrl_sig = 3'b000;
          6'b100101: alu_ctrl_sig = 3'b001;
          6'b101010: alu_ctrl_sig = 3'b111;
          default:   alu_ctrl_sig = 3'b010;
        endcase
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      BRANCH: begin
        alu_srcA     = 1'b1;
        alu_ctrl_sig = 3'b110;
        pc_src       = 2'b01;
        branch_eq    = 1'b1;
      end
      BNE: begin
        alu_srcA     = 1'b1;
        alu_ctrl_sig = 3'b110;
        pc_src       = 2'b01;
        branch_ne    = 1'b1;
      end
      ADDIEXEC: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
        state_d  = ADDIWB;
      end
      ADDIWB: reg_write_raw = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Architectural write enables are held off for as long as reset is asserted.
  assign ireg_enab = ireg_raw      & ~ctrl_bus.reset;
  assign reg_write = reg_write_raw & ~ctrl_bus.reset;
  assign mem_write = mem_write_raw & ~ctrl_bus.reset;
  assign pc_enab   = (pc_write | (branch_eq & zero) | (branch_ne & ~zero)) & ~ctrl_bus.reset;
  assign state     = state_q;

endmodule

// File: tb/tb_multi_controller.sv
// Directed bench for multi_controller: walks each instruction class through the FSM.
module tb_multi_controller;
  ctrl_bus_if bus();

  logic [5:0] op, funct;
  logic       zero;
  logic       i_or_d, ireg_enab, pc_enab, mem_to_reg, reg_dst, reg_write;
  logic       alu_srcA, mem_write, illegal;
  logic [1:0] pc_src, alu_srcB;
  logic [2:0] alu_ctrl_sig;
  logic [3:0] state;
  logic [19:0] act;

  int vectors = 0;
  int miscompares = 0;

  multi_controller dut (
    .ctrl_bus(bus.central), .op(op), .funct(funct), .zero(zero),
    .i_or_d(i_or_d), .ireg_enab(ireg_enab), .pc_src(pc_src), .pc_enab(pc_enab),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl_sig(alu_ctrl_sig),
    .mem_write(mem_write), .illegal(illegal), .state(state)
  );

  assign act = {state, i_or_d, ireg_enab, pc_src, pc_enab, mem_to_reg, reg_dst,
                reg_write, alu_srcA, alu_srcB, alu_ctrl_sig, mem_write, illegal};

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  // Packs hand-derived field values in the same order as act.
  function automatic logic [19:0] e(input logic [3:0] st, input logic iord, input logic ireg,
                                    input logic [1:0] pcs, input logic pce, input logic m2r,
                                    input logic rdst, input logic rw, input logic sa,
                                    input logic [1:0] sb, input logic [2:0] ac,
                                    input logic mw, input logic ill);
    return {st, iord, ireg, pcs, pce, m2r, rdst, rw, sa, sb, ac, mw, ill};
  endfunction

  task automatic step();
    @(negedge bus.clk);
    #1;
  endtask

  task automatic test_reset();
    bus.reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
    step(); step();
    vectors++; if (act !== e(0,0,0,2'b00,0,0,0,0,0,2'b01,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL reset_hold: got %h want %h", act, e(0,0,0,2'b00,0,0,0,0,0,2'b01,3'b010,0,0)); end
    bus.reset = 1'b0; #1;
    vectors++; if (act !== e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL reset_release_fetch: got %h want %h", act, e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)); end
    step(); step(); step();
    vectors++; if (act !== e(3,1,0,2'b00,0,0,0,0,0,2'b00,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL reach_memrd: got %h want %h", act, e(3,1,0,2'b00,0,0,0,0,0,2'b00,3'b010,0,0)); end
    bus.reset = 1'b1;
    step();
    vectors++; if (act !== e(0,0,0,2'b00,0,0,0,0,0,2'b01,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL reset_abort_edge1: got %h want %h", act, e(0,0,0,2'b00,0,0,0,0,0,2'b01,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(0,0,0,2'b00,0,0,0,0,0,2'b01,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL reset_abort_edge2: got %h want %h", act, e(0,0,0,2'b00,0,0,0,0,0,2'b01,3'b010,0,0)); end
    bus.reset = 1'b0; #1;
    vectors++; if (act !== e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL reset_abort_fetch: got %h want %h", act, e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)); end
  endtask

  task automatic test_lw();
    op = 6'b100011; #1;
    step();
    vectors++; if (act !== e(1,0,0,2'b00,0,0,0,0,0,2'b11,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL lw_decode: got %h want %h", act, e(1,0,0,2'b00,0,0,0,0,0,2'b11,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(2,0,0,2'b00,0,0,0,0,1,2'b10,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL lw_memadr: got %h want %h", act, e(2,0,0,2'b00,0,0,0,0,1,2'b10,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(3,1,0,2'b00,0,0,0,0,0,2'b00,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL lw_memrd: got %h want %h", act, e(3,1,0,2'b00,0,0,0,0,0,2'b00,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(4,0,0,2'b00,0,1,0,1,0,2'b00,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL lw_memwb: got %h want %h", act, e(4,0,0,2'b00,0,1,0,1,0,2'b00,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL lw_refetch: got %h want %h", act, e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)); end
  endtask

  task automatic test_sw();
    op = 6'b101011; #1;
    step(); step();
    vectors++; if (act !== e(2,0,0,2'b00,0,0,0,0,1,2'b10,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL sw_memadr: got %h want %h", act, e(2,0,0,2'b00,0,0,0,0,1,2'b10,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(5,1,0,2'b00,0,0,0,0,0,2'b00,3'b010,1,0)) begin miscompares++; $display("[TB] FAIL sw_memwr: got %h want %h", act, e(5,1,0,2'b00,0,0,0,0,0,2'b00,3'b010,1,0)); end
    step();
    vectors++; if (act !== e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL sw_refetch: got %h want %h", act, e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)); end
  endtask

  task automatic test_rtype();
    op = 6'b000000; funct = 6'b101010; #1;
    step();
    vectors++; if (act !== e(1,0,0,2'b00,0,0,0,0,0,2'b11,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL rtype_decode_ignores_funct: got %h want %h", act, e(1,0,0,2'b00,0,0,0,0,0,2'b11,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(6,0,0,2'b00,0,0,0,0,1,2'b00,3'b111,0,0)) begin miscompares++; $display("[TB] FAIL rtype_slt_execute: got %h want %h", act, e(6,0,0,2'b00,0,0,0,0,1,2'b00,3'b111,0,0)); end
    funct = 6'b100010; #1;
    vectors++; if (act !== e(6,0,0,2'b00,0,0,0,0,1,2'b00,3'b110,0,0)) begin miscompares++; $display("[TB] FAIL rtype_sub_execute: got %h want %h", act, e(6,0,0,2'b00,0,0,0,0,1,2'b00,3'b110,0,0)); end
    funct = 6'b100101; #1;
    vectors++; if (act !== e(6,0,0,2'b00,0,0,0,0,1,2'b00,3'b001,0,0)) begin miscompares++; $display("[TB] FAIL rtype_or_execute: got %h want %h", act, e(6,0,0,2'b00,0,0,0,0,1,2'b00,3'b001,0,0)); end
    funct = 6'b111111; #1;
    vectors++; if (act !== e(6,0,0,2'b00,0,0,0,0,1,2'b00,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL rtype_unknown_funct: got %h want %h", act, e(6,0,0,2'b00,0,0,0,0,1,2'b00,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(7,0,0,2'b00,0,0,1,1,0,2'b00,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL rtype_aluwb: got %h want %h", act, e(7,0,0,2'b00,0,0,1,1,0,2'b00,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL rtype_refetch: got %h want %h", act, e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)); end
  endtask

  task automatic test_addi();
    op = 6'b001000; #1;
    step(); step();
    vectors++; if (act !== e(9,0,0,2'b00,0,0,0,0,1,2'b10,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL addi_exec: got %h want %h", act, e(9,0,0,2'b00,0,0,0,0,1,2'b10,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(10,0,0,2'b00,0,0,0,1,0,2'b00,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL addi_wb: got %h want %h", act, e(10,0,0,2'b00,0,0,0,1,0,2'b00,3'b010,0,0)); end
    step();
  endtask

  task automatic test_branch();
    op = 6'b000100; zero = 1'b1; #1;
    step(); step();
    vectors++; if (act !== e(8,0,0,2'b01,1,0,0,0,1,2'b00,3'b110,0,0)) begin miscompares++; $display("[TB] FAIL beq_taken: got %h want %h", act, e(8,0,0,2'b01,1,0,0,0,1,2'b00,3'b110,0,0)); end
    step();
    vectors++; if (state !== 4'd0) begin miscompares++; $display("[TB] FAIL beq_taken_return: got %0d want 0", state); end
    zero = 1'b0;
    step(); step();
    vectors++; if (act !== e(8,0,0,2'b01,0,0,0,0,1,2'b00,3'b110,0,0)) begin miscompares++; $display("[TB] FAIL beq_not_taken: got %h want %h", act, e(8,0,0,2'b01,0,0,0,0,1,2'b00,3'b110,0,0)); end
    step();
    vectors++; if (state !== 4'd0) begin miscompares++; $display("[TB] FAIL beq_not_taken_return: got %0d want 0", state); end
  endtask

  task automatic test_bne();
    op = 6'b000101; zero = 1'b0; #1;
    step();
`ifdef CTRL_BNE_EN
    vectors++; if (act !== e(1,0,0,2'b00,0,0,0,0,0,2'b11,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL bne_decode: got %h want %h", act, e(1,0,0,2'b00,0,0,0,0,0,2'b11,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(12,0,0,2'b01,1,0,0,0,1,2'b00,3'b110,0,0)) begin miscompares++; $display("[TB] FAIL bne_taken: got %h want %h", act, e(12,0,0,2'b01,1,0,0,0,1,2'b00,3'b110,0,0)); end
    step();
`else
    vectors++; if (act !== e(1,0,0,2'b00,0,0,0,0,0,2'b11,3'b010,0,1)) begin miscompares++; $display("[TB] FAIL bne_illegal: got %h want %h", act, e(1,0,0,2'b00,0,0,0,0,0,2'b11,3'b010,0,1)); end
    step();
`endif
    vectors++; if (state !== 4'd0) begin miscompares++; $display("[TB] FAIL bne_return: got %0d want 0", state); end
  endtask

  task automatic test_jump();
    op = 6'b000010; #1;
    step(); step();
    vectors++; if (act !== e(11,0,0,2'b10,1,0,0,0,0,2'b00,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL jump: got %h want %h", act, e(11,0,0,2'b10,1,0,0,0,0,2'b00,3'b010,0,0)); end
    step();
  endtask

  task automatic test_illegal();
    op = 6'b111111; #1;
    vectors++; if (act !== e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL illegal_fetch: got %h want %h", act, e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)); end
    step();
    vectors++; if (act !== e(1,0,0,2'b00,0,0,0,0,0,2'b11,3'b010,0,1)) begin miscompares++; $display("[TB] FAIL illegal_decode: got %h want %h", act, e(1,0,0,2'b00,0,0,0,0,0,2'b11,3'b010,0,1)); end
    step();
    vectors++; if (act !== e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)) begin miscompares++; $display("[TB] FAIL illegal_return: got %h want %h", act, e(0,0,1,2'b00,1,0,0,0,0,2'b01,3'b010,0,0)); end
  endtask

  initial begin
    bus.reset = 1'b1;
    op = 6'b0; funct = 6'b0; zero = 1'b0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_addi();
    test_branch();
    test_bne();
    test_jump();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
